ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between two requesters, A and B.
//  The RAM has 1-cycle read latency, gives read priority over write, and its
//  contents are not reset. After reset this block scrubs the RAM to zero, then
//  arbitrates round-robin and returns read data to the requester that issued it.
//  Sits between the RAM instance and two client engines.
// PARAMETERS
//  ADDR_WIDTH  12  RAM address width; depth = 2**ADDR_WIDTH
//  DATA_WIDTH  16  RAM word width
//  INIT_EN     1   1: zero-scrub the RAM after reset; 0: go straight to RUN
// PORTS
//  CLK        in   1    clock; all state updates on posedge
//  RST_N      in   1    asynchronous active-low reset
//  A_REQ      in   1    A command valid; hold it and its fields until A_GNT
//  A_WE       in   1    1 = write, 0 = read
//  A_ADDR     in   AW   A address
//  A_WDATA    in   DW   A write data
//  A_GNT      out  1    combinational; command accepted at this edge
//  A_RVALID   out  1    A read data valid (1-cycle pulse)
//  A_RDATA    out  DW   A read data; meaningful only while A_RVALID
//  B_*        --   --   same set as A_*, for requester B
//  RAM_RDEN   out  1    RAM read enable (registered)
//  RAM_WREN   out  1    RAM write enable (registered)
//  RAM_ADDR   out  AW   RAM address (registered)
//  RAM_WDATA  out  DW   RAM write data (registered)
//  RAM_RDATA  in   DW   RAM registered read data
//  INIT_DONE  out  1    high once the scrub is complete
// BEHAVIOUR
//  Reset values: RAM_RDEN/RAM_WREN/A_RVALID/B_RVALID/INIT_DONE = 0;
//   RAM_ADDR/RAM_WDATA = 0; FSM = INIT (RUN if INIT_EN=0); scrub counter = 0;
//   last-grant pointer = B, so A wins the first contention.
//  FSM INIT: each cycle register RAM_WREN=1, RAM_ADDR=cnt, RAM_WDATA=0; cnt++.
//   The write with cnt = 2**AW-1 moves the FSM to RUN. INIT_DONE rises
//   2**AW+1 cycles after reset release. No GNT is asserted in INIT.
//  FSM RUN: GNT_x = REQ_x & win_x. If only one requester asserts REQ, it wins.
//   If both assert REQ, the requester not granted last wins. The pointer
//   updates only on a grant. At most one grant per cycle.
//  Accept edge E0: RAM_* takes the winner's command, with RAM_RDEN = ~WE and
//   RAM_WREN = WE. RDEN and WREN are never both 1. With no grant, both are 0
//   for the next cycle. Throughput is 1 command per cycle.
//  Reads: at E1 the RAM samples the command. At E1 an owner tag is registered
//   and x_RVALID goes high for the cycle after E1. x_RDATA = RAM_RDATA.
//   Latency is 2 edges from acceptance, and read data stays in issue order.
//   The non-owner's RDATA is held at 0.
//  Ordering: a write accepted at E0 followed by a read of the same address
//   accepted at E0+1 returns the new data, because RAM order = accept order.
//  Reset mid-operation: an in-flight read is dropped with no RVALID, and the
//   FSM returns to INIT. The RAM shares RST_N.
//  Address and data pass through unchanged: no wrap or width conversion.
// TESTING
//  1 INIT_EN=1, AW=4: release reset -> 16 consecutive RAM_WREN writes of 0 to
//    addr 0..15; INIT_DONE=1 on cycle 17; A_REQ held during scrub -> no A_GNT.
//  2 A writes 0xBEEF@0x005, then A reads 0x005 on the next cycle -> A_RVALID
//    on the second cycle after the read grant, A_RDATA=0xBEEF, B_RVALID=0.
//  3 A and B both hold read REQ for 4 cycles -> grants A,B,A,B; each RVALID
//    matches its owner; after the scrub every read returns 0x0000.
//  4 B alone streams reads of 0x010..0x013 back-to-back -> 4 grants in
//    4 cycles; B_RVALID on 4 consecutive cycles with data in address order.
//  5 Assert RST_N=0 the cycle after a read grant -> no RVALID;
//    RAM_RDEN=RAM_WREN=0 immediately; the scrub restarts from address 0.
//  6 Every cycle of random traffic: assert !(RAM_RDEN & RAM_WREN) and
//    $onehot0({A_GNT,B_GNT}).

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port synchronous RAM (1-cycle read latency, read wins
//   over write, contents not reset) between two requesters, A and B. After
//   reset the RAM is scrubbed to zero. The block then arbitrates round-robin
//   and steers each read return to the requester that issued it.
//
// Ports
//   CLK, RST_N              clock (posedge) and asynchronous active-low reset
//   A_REQ/A_WE/A_ADDR/A_WDATA
//                           requester A command; held until A_GNT
//   A_GNT                   combinational accept, command taken at this edge
//   A_RVALID/A_RDATA        A read return, one-cycle pulse; data 0 otherwise
//   B_*                     same set for requester B
//   RAM_RDEN/RAM_WREN/RAM_ADDR/RAM_WDATA
//                           registered RAM command
//   RAM_RDATA               registered RAM read data
//   INIT_DONE               high once the scrub has completed
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16,
   parameter bit INIT_EN    = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  A_REQ,
   input  logic                  A_WE,
   input  logic [ADDR_WIDTH-1:0] A_ADDR,
   input  logic [DATA_WIDTH-1:0] A_WDATA,
   output logic                  A_GNT,
   output logic                  A_RVALID,
   output logic [DATA_WIDTH-1:0] A_RDATA,
   input  logic                  B_REQ,
   input  logic                  B_WE,
   input  logic [ADDR_WIDTH-1:0] B_ADDR,
   input  logic [DATA_WIDTH-1:0] B_WDATA,
   output logic                  B_GNT,
   output logic                  B_RVALID,
   output logic [DATA_WIDTH-1:0] B_RDATA,
   output logic                  RAM_RDEN,
   output logic                  RAM_WREN,
   output logic [ADDR_WIDTH-1:0] RAM_ADDR,
   output logic [DATA_WIDTH-1:0] RAM_WDATA,
   input  logic [DATA_WIDTH-1:0] RAM_RDATA,
   output logic                  INIT_DONE
);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] scrub_cnt;
   logic                  last_b;      // 1: B was granted most recently
   logic                  run;
   logic                  any_gnt;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  own_b_p0;
   logic                  vld_p1;
   logic                  own_b_p1;

   // Arbitration: a lone requester always wins; under contention the one
   // not granted last time wins. Nothing is granted while scrubbing.
   assign run     = (state == ST_RUN);
   assign A_GNT   = run & A_REQ & (~B_REQ | last_b);
   assign B_GNT   = run & B_REQ & (~A_REQ | ~last_b);
   assign any_gnt = A_GNT | B_GNT;

   assign sel_we    = B_GNT ? B_WE    : A_WE;
   assign sel_addr  = B_GNT ? B_ADDR  : A_ADDR;
   assign sel_wdata = B_GNT ? B_WDATA : A_WDATA;

   // ---- stage p0: accept edge, winner's command onto the RAM bus ----
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= INIT_EN ? ST_INIT : ST_RUN;
         scrub_cnt <= '0;
         last_b    <= 1'b1;
         RAM_RDEN  <= 1'b0;
         RAM_WREN  <= 1'b0;
         RAM_ADDR  <= '0;
         RAM_WDATA <= '0;
         own_b_p0  <= 1'b0;
      end else if (state == ST_INIT) begin
         RAM_RDEN  <= 1'b0;
         RAM_WREN  <= 1'b1;
         RAM_ADDR  <= scrub_cnt;
         RAM_WDATA <= '0;
         scrub_cnt <= scrub_cnt + ADDR_WIDTH'(1);
         if (scrub_cnt == '1) begin
            state <= ST_RUN;
         end
      end else begin
         RAM_RDEN <= any_gnt & ~sel_we;
         RAM_WREN <= any_gnt & sel_we;
         if (any_gnt) begin
            RAM_ADDR  <= sel_addr;
            RAM_WDATA <= sel_wdata;
            own_b_p0  <= B_GNT;
            last_b    <= B_GNT;
         end
      end
   end

   // ---- stage p1: RAM samples the read; owner tag follows it ----
   // INIT_DONE is taken from the state one edge late so it rises only after
   // the last scrub write has actually been sampled by the RAM.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vld_p1    <= 1'b0;
         own_b_p1  <= 1'b0;
         INIT_DONE <= 1'b0;
      end else begin
         vld_p1    <= RAM_RDEN;
         own_b_p1  <= own_b_p0;
         INIT_DONE <= run;
      end
   end

   // ---- return: RAM read data steered to its owner, zero elsewhere ----
   assign A_RVALID = vld_p1 & ~own_b_p1;
   assign B_RVALID = vld_p1 &  own_b_p1;
   assign A_RDATA  = A_RVALID ? RAM_RDATA : '0;
   assign B_RDATA  = B_RVALID ? RAM_RDATA : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Directed bench for ram_port_arbiter with a behavioural single-port RAM
//   (1-cycle read latency, read priority, garbage contents after reset).
//   Inputs change on the falling edge; outputs are sampled away from the
//   rising edge.
module tb_ram_port_arbiter;

   localparam int AW    = 5;
   localparam int DW    = 16;
   localparam int DEPTH = 1 << AW;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          a_req   = 1'b0;
   logic          a_we    = 1'b0;
   logic [AW-1:0] a_addr  = '0;
   logic [DW-1:0] a_wdata = '0;
   logic          b_req   = 1'b0;
   logic          b_we    = 1'b0;
   logic [AW-1:0] b_addr  = '0;
   logic [DW-1:0] b_wdata = '0;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          ram_rden, ram_wren, init_done;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   logic [DW-1:0] mem [DEPTH];

   int vectors     = 0;
   int miscompares = 0;

   typedef struct packed {
      logic          own_b;
      logic [DW-1:0] d;
   } rd_t;

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b1)) dut (
      .CLK(clk), .RST_N(rst_n),
      .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
      .A_GNT(a_gnt), .A_RVALID(a_rvalid), .A_RDATA(a_rdata),
      .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
      .B_GNT(b_gnt), .B_RVALID(b_rvalid), .B_RDATA(b_rdata),
      .RAM_RDEN(ram_rden), .RAM_WREN(ram_wren), .RAM_ADDR(ram_addr),
      .RAM_WDATA(ram_wdata), .RAM_RDATA(ram_rdata), .INIT_DONE(init_done)
   );

   // Behavioural RAM: contents become non-zero garbage during reset so the
   // scrub is observable.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(16'hA5A5 ^ i);
         ram_rdata <= '0;
      end else if (ram_rden) begin
         ram_rdata <= mem[ram_addr];
      end else if (ram_wren) begin
         mem[ram_addr] <= ram_wdata;
      end
   end

   task automatic test_reset;
      a_req = 1'b1; a_we = 1'b0; a_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({ram_rden, ram_wren, a_rvalid, b_rvalid, init_done, a_gnt, b_gnt} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: rden/wren/arv/brv/done/agnt/bgnt=%b, wanted 0000000",
                  {ram_rden, ram_wren, a_rvalid, b_rvalid, init_done, a_gnt, b_gnt});
      end
      vectors++;
      if (ram_addr !== '0 || ram_wdata !== '0) begin
         miscompares++;
         $display("FAIL reset_bus: addr=%h wdata=%h, wanted 0/0", ram_addr, ram_wdata);
      end
      vectors++;
      if (a_rdata !== '0 || b_rdata !== '0) begin
         miscompares++;
         $display("FAIL reset_rdata: a=%h b=%h, wanted 0/0", a_rdata, b_rdata);
      end
   endtask

   // Release reset and watch the scrub; A keeps requesting throughout.
   task automatic test_init;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge clk);
         if (k > 0) begin
            vectors++;
            if (ram_wren !== 1'b1 || ram_rden !== 1'b0 || ram_addr !== AW'(k - 1) || ram_wdata !== '0) begin
               miscompares++;
               $display("FAIL init_write k=%0d: wren=%b rden=%b addr=%0d wdata=%h, wanted 1/0/%0d/0",
                        k, ram_wren, ram_rden, ram_addr, ram_wdata, k - 1);
            end
         end
         vectors++;
         if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL init_nogrant k=%0d: agnt=%b bgnt=%b done=%b, wanted 0/0/0",
                     k, a_gnt, b_gnt, init_done);
         end
         if (k == DEPTH - 1) a_req = 1'b0;
      end
      @(negedge clk);
      vectors++;
      if (ram_wren !== 1'b1 || ram_addr !== AW'(DEPTH - 1) || init_done !== 1'b0) begin
         miscompares++;
         $display("FAIL init_last: wren=%b addr=%0d done=%b, wanted 1/%0d/0",
                  ram_wren, ram_addr, init_done, DEPTH - 1);
      end
      @(negedge clk);
      vectors++;
      if (init_done !== 1'b1 || ram_wren !== 1'b0 || ram_rden !== 1'b0) begin
         miscompares++;
         $display("FAIL init_done: done=%b wren=%b rden=%b, wanted 1/0/0",
                  init_done, ram_wren, ram_rden);
      end
   endtask

   // A and B both read for 4 cycles: grants alternate A,B,A,B.
   task automatic test_contention;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         a_we = 1'b0; b_we = 1'b0; a_addr = AW'(8); b_addr = AW'(9);
         a_req = (i < 4); b_req = (i < 4);
         #1;
         if (i < 4) begin
            vectors++;
            if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
               miscompares++;
               $display("FAIL rr_grant i=%0d: agnt/bgnt=%b, wanted %b",
                        i, {a_gnt, b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
         end
         if (i >= 1 && i <= 4) begin
            vectors++;
            if (ram_rden !== 1'b1 || ram_wren !== 1'b0 || ram_addr !== (((i - 1) % 2 == 0) ? AW'(8) : AW'(9))) begin
               miscompares++;
               $display("FAIL rr_bus i=%0d: rden=%b wren=%b addr=%0d, wanted 1/0/%0d",
                        i, ram_rden, ram_wren, ram_addr, ((i - 1) % 2 == 0) ? 8 : 9);
            end
         end
         if (i >= 2 && i <= 5) begin
            vectors++;
            if ({a_rvalid, b_rvalid} !== (((i - 2) % 2 == 0) ? 2'b10 : 2'b01) || a_rdata !== '0 || b_rdata !== '0) begin
               miscompares++;
               $display("FAIL rr_return i=%0d: arv/brv=%b ad=%h bd=%h, wanted %b/0000/0000",
                        i, {a_rvalid, b_rvalid}, a_rdata, b_rdata, ((i - 2) % 2 == 0) ? 2'b10 : 2'b01);
            end
         end
         if (i == 6) begin
            vectors++;
            if ({a_rvalid, b_rvalid} !== 2'b00) begin
               miscompares++;
               $display("FAIL rr_idle: arv/brv=%b, wanted 00", {a_rvalid, b_rvalid});
            end
         end
      end
   endtask

   // A writes 0xBEEF to 5, then reads it back on the next cycle.
   task automatic test_write_read;
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = AW'(5); a_wdata = 16'hBEEF;
      #1;
      vectors++;
      if ({a_gnt, b_gnt} !== 2'b10) begin
         miscompares++;
         $display("FAIL wr_grant: agnt/bgnt=%b, wanted 10", {a_gnt, b_gnt});
      end
      @(negedge clk);
      vectors++;
      if (ram_wren !== 1'b1 || ram_rden !== 1'b0 || ram_addr !== AW'(5) || ram_wdata !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL wr_bus: wren=%b rden=%b addr=%0d wdata=%h, wanted 1/0/5/beef",
                  ram_wren, ram_rden, ram_addr, ram_wdata);
      end
      a_we = 1'b0;
      #1;
      vectors++;
      if (a_gnt !== 1'b1) begin
         miscompares++;
         $display("FAIL rd_grant: agnt=%b, wanted 1", a_gnt);
      end
      @(negedge clk);
      a_req = 1'b0;
      vectors++;
      if (ram_rden !== 1'b1 || ram_wren !== 1'b0 || ram_addr !== AW'(5) || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL rd_bus: rden=%b wren=%b addr=%0d arv=%b brv=%b, wanted 1/0/5/0/0",
                  ram_rden, ram_wren, ram_addr, a_rvalid, b_rvalid);
      end
      @(negedge clk);
      vectors++;
      if (a_rvalid !== 1'b1 || a_rdata !== 16'hBEEF || b_rvalid !== 1'b0 || b_rdata !== '0) begin
         miscompares++;
         $display("FAIL rd_return: arv=%b ad=%h brv=%b bd=%h, wanted 1/beef/0/0000",
                  a_rvalid, a_rdata, b_rvalid, b_rdata);
      end
      @(negedge clk);
      vectors++;
      if (a_rvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL rd_pulse: arv=%b, wanted 0", a_rvalid);
      end
   endtask

   // A fills 0x10..0x13, then B streams reads of them back-to-back.
   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a_req = 1'b1; a_we = 1'b1; a_addr = AW'(16 + i); a_wdata = DW'(16'h1000 + i);
         #1;
         vectors++;
         if (a_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_grant i=%0d: agnt=%b, wanted 1", i, a_gnt);
         end
      end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         a_req = 1'b0;
         b_req = (i < 4); b_we = 1'b0; b_addr = AW'(16 + (i % 4));
         #1;
         if (i < 4) begin
            vectors++;
            if ({a_gnt, b_gnt} !== 2'b01) begin
               miscompares++;
               $display("FAIL b2b_grant i=%0d: agnt/bgnt=%b, wanted 01", i, {a_gnt, b_gnt});
            end
         end
         if (i >= 2 && i <= 5) begin
            vectors++;
            if (b_rvalid !== 1'b1 || b_rdata !== DW'(16'h1000 + i - 2) || a_rvalid !== 1'b0 || a_rdata !== '0) begin
               miscompares++;
               $display("FAIL b2b_return i=%0d: brv=%b bd=%h arv=%b ad=%h, wanted 1/%h/0/0000",
                        i, b_rvalid, b_rdata, a_rvalid, a_rdata, 16'h1000 + i - 2);
            end
         end
         if (i == 6) begin
            vectors++;
            if (b_rvalid !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_end: brv=%b, wanted 0", b_rvalid);
            end
         end
      end
   endtask

   // Reset lands the cycle after a read grant: the read never returns and
   // the scrub starts over from address 0.
   task automatic test_reset_midop;
      int n;
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_addr = AW'(5);
      #1;
      vectors++;
      if (a_gnt !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_grant: agnt=%b, wanted 1", a_gnt);
      end
      @(negedge clk);
      a_req = 1'b0;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (ram_rden !== 1'b0 || ram_wren !== 1'b0 || a_rvalid !== 1'b0 || init_done !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: rden=%b wren=%b arv=%b done=%b, wanted 0/0/0/0",
                  ram_rden, ram_wren, a_rvalid, init_done);
      end
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_norvalid: arv=%b brv=%b, wanted 0/0", a_rvalid, b_rvalid);
         end
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      a_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vectors++;
         if (a_gnt !== 1'b0 || a_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rescrub_nogrant k=%0d: agnt=%b arv=%b, wanted 0/0", k, a_gnt, a_rvalid);
         end
         if (k > 0) begin
            vectors++;
            if (ram_wren !== 1'b1 || ram_addr !== AW'(k - 1)) begin
               miscompares++;
               $display("FAIL rescrub_addr k=%0d: wren=%b addr=%0d, wanted 1/%0d",
                        k, ram_wren, ram_addr, k - 1);
            end
         end
      end
      a_req = 1'b0;
      n = 0;
      while (init_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (init_done !== 1'b1) begin
         miscompares++;
         $display("FAIL rescrub_timeout: done=%b after %0d cycles, wanted 1", init_done, n);
      end
   endtask

   // Random traffic from both sides with a shadow memory and an in-order
   // return queue; checks exclusivity invariants every cycle.
   task automatic test_random;
      logic [DW-1:0] sh [DEPTH];
      rd_t           q [$];
      rd_t           e;
      logic          a_done, b_done;
      for (int i = 0; i < DEPTH; i++) sh[i] = '0;
      a_done = 1'b0; b_done = 1'b0;
      for (int c = 0; c < 260; c++) begin
         @(negedge clk);
         if (a_rvalid === 1'b1 || b_rvalid === 1'b1) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL rnd_spurious c=%0d: arv=%b brv=%b with nothing outstanding", c, a_rvalid, b_rvalid);
            end else begin
               e = q.pop_front();
               if ({a_rvalid, b_rvalid} !== (e.own_b ? 2'b01 : 2'b10) ||
                   (e.own_b ? b_rdata : a_rdata) !== e.d ||
                   (e.own_b ? a_rdata : b_rdata) !== '0) begin
                  miscompares++;
                  $display("FAIL rnd_return c=%0d: arv/brv=%b ad=%h bd=%h, wanted owner_b=%b data=%h",
                           c, {a_rvalid, b_rvalid}, a_rdata, b_rdata, e.own_b, e.d);
               end
            end
         end
         vectors++;
         if ((ram_rden & ram_wren) !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd_rdwr c=%0d: rden=%b wren=%b, wanted not both", c, ram_rden, ram_wren);
         end
         if (a_done) a_req = 1'b0;
         if (b_done) b_req = 1'b0;
         a_done = 1'b0; b_done = 1'b0;
         if (c < 250 && !a_req && $urandom_range(0, 3) != 0) begin
            a_req = 1'b1; a_we = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom);
         end
         if (c < 250 && !b_req && $urandom_range(0, 3) != 0) begin
            b_req = 1'b1; b_we = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom);
         end
         #1;
         vectors++;
         if (!$onehot0({a_gnt, b_gnt}) || (a_gnt & ~a_req) || (b_gnt & ~b_req) || ((a_req | b_req) & ~(a_gnt | b_gnt))) begin
            miscompares++;
            $display("FAIL rnd_grant c=%0d: req=%b gnt=%b, wanted one grant per busy cycle",
                     c, {a_req, b_req}, {a_gnt, b_gnt});
         end
         if (a_gnt) begin
            if (a_we) sh[a_addr] = a_wdata;
            else      q.push_back({1'b0, sh[a_addr]});
            a_done = 1'b1;
         end else if (b_gnt) begin
            if (b_we) sh[b_addr] = b_wdata;
            else      q.push_back({1'b1, sh[b_addr]});
            b_done = 1'b1;
         end
      end
      a_req = 1'b0; b_req = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL rnd_drain: %0d reads never returned, wanted 0", q.size());
      end
   endtask

   initial begin
      test_reset;
      test_init;
      test_contention;
      test_write_read;
      test_back_to_back;
      test_reset_midop;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
